// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, RV32I width codes and legality helper.
package lsu_pkg;

  localparam int DEPTH_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_RESP,
    S_FAULT
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have B/H/W; loads add the unsigned variants.
  function automatic logic f3_legal(
    input logic       st,
    input logic [2:0] f3
  );
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!st) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extract/extend for loads and lane merge for
// sub-word stores against a full memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [31:0] w_sh;

  assign w_sh = i_word >> {i_lane, 3'b000};

  // Load result: pick the lane, then sign- or zero-extend.
  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_load = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_BU:   o_load = {24'd0, w_sh[7:0]};
      F3_HU:   o_load = {16'd0, w_sh[15:0]};
      default: o_load = i_word;
    endcase
  end

  // Store merge: replace only the addressed byte or halfword.
  always_comb begin
    o_merge = i_word;
    if (i_funct3[0]) begin
      if (i_lane[1]) o_merge[31:16] = i_wdata;
      else           o_merge[15:0]  = i_wdata;
    end else begin
      case (i_lane)
        2'd0:    o_merge[7:0]   = i_wdata[7:0];
        2'd1:    o_merge[15:8]  = i_wdata[7:0];
        2'd2:    o_merge[23:16] = i_wdata[7:0];
        default: o_merge[31:24] = i_wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// RV32I load/store unit in front of a word-only memory.
// Sub-word stores become read-modify-write sequences.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_t      r_state;
  state_t      w_next;

  logic        r_store;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;

  logic        w_mis;
  logic        w_oor;
  logic        w_fault;
  logic        w_sw;
  logic        w_acc;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_acc = (r_state == S_IDLE) && req;

  // Fault screen on the live request, before any capture.
  always_comb begin
    w_mis = 1'b0;
    if (funct3 == F3_H || funct3 == F3_HU)
      w_mis = addr[0];
    else if (funct3 == F3_W)
      w_mis = (addr[1:0] != 2'b00);
    w_oor   = ({2'b00, addr[31:2]} >= 32'(DEPTH));
    w_fault = !f3_legal(store, funct3) || w_mis || w_oor;
    w_sw    = store && (funct3 == F3_W);
  end

  // State register; async reset abandons any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          unique case (1'b1)
            w_fault:          w_next = S_FAULT;
            (!w_fault && w_sw): w_next = S_WRITE;
            default:          w_next = S_READ;
          endcase
        end
      end
      S_READ:  w_next = S_MERGE;
      S_MERGE: w_next = r_store ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_RESP) || (r_state == S_FAULT);
    err    = (r_state == S_FAULT);
    mem_we = (r_state == S_WRITE);
    mem_a  = 32'd0;
    mem_wd = 32'd0;
    if (r_state == S_READ || r_state == S_MERGE ||
        r_state == S_WRITE)
      mem_a = {2'b00, r_addr[31:2]};
    if (r_state == S_WRITE)
      mem_wd = (r_f3 == F3_W) ? r_wdata : r_merge;
  end

  // Capture the request when it is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_store <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_acc) begin
      r_store <= store;
      r_f3    <= funct3;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  lsu_align u_align (
    .i_funct3 (r_f3),
    .i_lane   (r_addr[1:0]),
    .i_word   (mem_rd),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // Merge word for stores, load result held until next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_merge <= 32'd0;
      r_rdata <= 32'd0;
    end else if (r_state == S_MERGE) begin
      if (r_store) r_merge <= w_merge;
      else         r_rdata <= w_load;
    end
  end

  assign rdata = r_rdata;

endmodule
